cpu_boot_sequencer: RTL and testbench
=====================================

CPU_BOOT_SEQUENCER -- requirements
Module: cpu_boot_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, RAM word-address width.
REQ-002 SHALL have parameter MAILBOX, default 13'h1FFF, the address whose CPU write signals program completion.
REQ-003 SHALL have parameter TIMEOUT, default 16'hFFFF, the RUN-cycle limit before a forced halt.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports: load_valid in 1; load_data in 16; load_last in 1; load_ready out 1, the program-load stream.
REQ-006 SHALL have ports: cpu_rst out 1, reset to CPU; cpu_wrEn in 1; cpu_addr in ADDR_W; cpu_wdata in 16, the CPU RAM request.
REQ-007 SHALL have ports: ram_wrEn out 1; ram_addr out ADDR_W; ram_wdata out 16; ram_rdata in 16, a single-port RAM with synchronous write and 1-cycle read latency.
REQ-008 SHALL have ports: start in 1, reload request; halted out 1; timed_out out 1; halt_code out 16.
REQ-009 SHALL have ports: dbg_req in 1; dbg_addr in ADDR_W; dbg_ack out 1; dbg_rdata out 16, the debug read port.

Function
REQ-010 SHALL implement states LOAD, RUN, HALT and DBG_WAIT; the state, load pointer, cycle counter, halt_code, timed_out and dbg_rdata SHALL be registered.
REQ-011 LOAD: load_ready=1, cpu_rst=1, halted=0; when load_valid=1, the block SHALL drive ram_wrEn=1, ram_addr=load_ptr and ram_wdata=load_data in that cycle, then increment load_ptr.
REQ-012 load_ptr SHALL wrap from 2^ADDR_W-1 to 0 with no error.
REQ-013 An accepted beat with load_last=1 SHALL be written, and the next state SHALL be RUN with the cycle counter cleared; load_last without load_valid SHALL be ignored.
REQ-014 RUN: cpu_rst=0, load_ready=0; ram_wrEn/ram_addr/ram_wdata SHALL combinationally equal cpu_wrEn/cpu_addr/cpu_wdata, and the CPU SHALL see ram_rdata directly with 1-cycle latency, with no stall.
REQ-015 RUN: the cycle counter SHALL increment every cycle, saturating at TIMEOUT.
REQ-016 RUN: cpu_wrEn=1 with cpu_addr==MAILBOX SHALL still write the RAM, latch halt_code=cpu_wdata, and make the next state HALT.
REQ-017 RUN: counter==TIMEOUT with no mailbox write in that cycle SHALL set timed_out=1, leave halt_code unchanged, and make the next state HALT; if both events occur in the same cycle, the mailbox SHALL win and timed_out SHALL stay 0.
REQ-018 HALT: halted=1, cpu_rst=1, load_ready=0, ram_wrEn=0; CPU request inputs SHALL be ignored.
REQ-019 HALT with dbg_req=1: ram_addr=dbg_addr that cycle, and the next state SHALL be DBG_WAIT.
REQ-020 DBG_WAIT: dbg_rdata SHALL latch ram_rdata, and the next state SHALL be HALT; dbg_ack SHALL pulse exactly 1 cycle, the cycle after DBG_WAIT, with dbg_rdata valid while dbg_ack=1.
REQ-021 dbg_req outside HALT SHALL be ignored, with no ack ever issued.
REQ-022 HALT with start=1 and dbg_req=0: the next state SHALL be LOAD, with load_ptr=0 and timed_out=0 cleared; halt_code SHALL be kept until the next mailbox write.
REQ-023 HALT with start=1 and dbg_req=1 in the same cycle: the debug request SHALL win, and start SHALL be ignored that cycle.
REQ-024 start SHALL be ignored in LOAD, RUN and DBG_WAIT.
REQ-025 When not otherwise specified, RAM outputs SHALL be 0.

Reset
REQ-026 rst=1 SHALL, in any state including mid-load or mid-run, force at the next edge: state=LOAD, load_ptr=0, counter=0, halt_code=0, timed_out=0, dbg_rdata=0, dbg_ack=0.
REQ-027 While rst=1, outputs SHALL be cpu_rst=1, ram_wrEn=0, load_ready=0, halted=0.
REQ-028 A load beat presented during rst SHALL NOT be written.

Verification
REQ-029 Load 3 words 16'hC005, 16'hE1FF, 16'h0000 (last on the third) -> RAM[0..2] written in consecutive cycles; cpu_rst falls the cycle after the third write.
REQ-030 RUN with a CPU write of 16'h00AB to 13'h1FFF -> RAM[1FFF]=00AB, halted=1 next cycle, halt_code=00AB, timed_out=0, cpu_rst=1.
REQ-031 TIMEOUT=16 with a CPU that never writes the mailbox -> halted=1 and timed_out=1 after 17 RUN cycles; halt_code unchanged.
REQ-032 In HALT, dbg_req with dbg_addr=2 -> dbg_ack=1 two cycles later with dbg_rdata=RAM[2]; start asserted the same cycle as dbg_req -> state remains HALT.
REQ-033 Load of 8193 words -> the last word overwrites RAM[0] (wrap).
REQ-034 rst pulsed mid-RUN -> next cycle state=LOAD, cpu_rst=1, load_ptr=0, halt_code=0.

Source files
------------

// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer for a small CPU sharing a single-port RAM.
// Loads a program image from a ready/valid stream, releases the CPU, and
// watches for a mailbox write or a run-cycle timeout to halt it. While
// halted, a debug port can read RAM one word at a time. A start request
// then reloads the image.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_LOAD     | CPU held in reset, stream beats written to RAM at load_ptr
// S_RUN      | CPU owns the RAM port, cycle counter running
// S_HALT     | CPU held in reset, waiting for a debug read or a start
// S_DBG_WAIT | debug read data returning from RAM, captured into dbg_rdata

module cpu_boot_sequencer #(
    parameter int                ADDR_W  = 13,
    parameter logic [ADDR_W-1:0] MAILBOX = 13'h1FFF,
    parameter logic [15:0]       TIMEOUT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              load_valid,
    input  logic [15:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,

    output logic              cpu_rst,
    input  logic              cpu_wrEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,

    output logic              ram_wrEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,

    input  logic              start,
    output logic              halted,
    output logic              timed_out,
    output logic [15:0]       halt_code,

    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [15:0]       dbg_rdata
);

    localparam logic [1:0] S_LOAD     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_HALT     = 2'd2;
    localparam logic [1:0] S_DBG_WAIT = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] load_ptr;
    logic [15:0]       cycle_cnt;

    logic load_beat;
    logic load_done;
    logic mbox_hit;
    logic cnt_done;
    logic dbg_take;
    logic reload;

    // Event decode shared by the next-state logic and the register updates.
    always_comb begin
        load_beat = (state == S_LOAD) && load_valid;
        load_done = load_beat && load_last;
        mbox_hit  = (state == S_RUN) && cpu_wrEn && (cpu_addr == MAILBOX);
        cnt_done  = (state == S_RUN) && (cycle_cnt == TIMEOUT);
        // A debug request takes priority over a reload in the same cycle.
        dbg_take  = (state == S_HALT) && dbg_req;
        reload    = (state == S_HALT) && !dbg_req && start;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (load_done) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (mbox_hit || cnt_done) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (dbg_take) begin
                    state_nxt = S_DBG_WAIT;
                end else if (reload) begin
                    state_nxt = S_LOAD;
                end
            end
            S_DBG_WAIT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // State register and the load pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LOAD;
            load_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (reload) begin
                load_ptr <= '0;
            end else if (load_beat) begin
                // Natural wrap at the top of the address space.
                load_ptr <= load_ptr + 1'b1;
            end
        end
    end

    // Run-cycle counter: cleared on the final load beat, saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (load_done) begin
            cycle_cnt <= '0;
        end else if ((state == S_RUN) && (cycle_cnt != TIMEOUT)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    // Halt status: a mailbox write wins over a coincident timeout, and
    // halt_code survives a reload so software can still inspect it.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_code <= '0;
            timed_out <= 1'b0;
        end else begin
            if (mbox_hit) begin
                halt_code <= cpu_wdata;
            end else if (cnt_done) begin
                timed_out <= 1'b1;
            end
            if (reload) begin
                timed_out <= 1'b0;
            end
        end
    end

    // Debug read capture; the ack follows the capture cycle by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rdata <= '0;
            dbg_ack   <= 1'b0;
        end else begin
            dbg_ack <= (state == S_DBG_WAIT);
            if (state == S_DBG_WAIT) begin
                dbg_rdata <= ram_rdata;
            end
        end
    end

    // RAM port mux and status outputs; reset forces the safe values.
    always_comb begin
        load_ready = 1'b0;
        cpu_rst    = 1'b1;
        halted     = 1'b0;
        ram_wrEn   = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        if (!rst) begin
            case (state)
                S_LOAD: begin
                    load_ready = 1'b1;
                    if (load_valid) begin
                        ram_wrEn  = 1'b1;
                        ram_addr  = load_ptr;
                        ram_wdata = load_data;
                    end
                end
                S_RUN: begin
                    cpu_rst   = 1'b0;
                    ram_wrEn  = cpu_wrEn;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (dbg_req) begin
                        ram_addr = dbg_addr;
                    end
                end
                S_DBG_WAIT: begin
                    // Still halted from the outside; read data is in flight.
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench for cpu_boot_sequencer with a behavioural single-port RAM.
module tb_cpu_boot_sequencer;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic [15:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              cpu_rst;
    logic              cpu_wrEn;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              ram_wrEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;
    logic              start;
    logic              halted;
    logic              timed_out;
    logic [15:0]       halt_code;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [15:0]       dbg_rdata;

    logic              mem_init;
    logic [15:0]       mem [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    cpu_boot_sequencer #(
        .ADDR_W (ADDR_W),
        .MAILBOX(13'h1FFF),
        .TIMEOUT(16'd16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .cpu_rst   (cpu_rst),
        .cpu_wrEn  (cpu_wrEn),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .ram_wrEn  (ram_wrEn),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .start     (start),
        .halted    (halted),
        .timed_out (timed_out),
        .halt_code (halt_code),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: synchronous write, registered read (read-before-write).
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
        end else if (ram_wrEn) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic idle();
        load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0;
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = 16'h0000;
        start = 1'b0; dbg_req = 1'b0; dbg_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        load_valid = 1'b1; load_data = 16'h5555; load_last = 1'b1;
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (ram_wrEn !== 1'b0) begin errors++; $display("FAIL rst_ram_wrEn: got %b expected 0", ram_wrEn); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready: got %b expected 0", load_ready); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        tick();
        rst = 1'b0; idle();
        @(negedge clk);
        checks++; if (mem[0] !== 16'h0000) begin errors++; $display("FAIL rst_beat_dropped: got %h expected 0000", mem[0]); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL post_rst_load_ready: got %b expected 1", load_ready); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL post_rst_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (halt_code !== 16'h0000) begin errors++; $display("FAIL post_rst_halt_code: got %h expected 0000", halt_code); end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL post_rst_timed_out: got %b expected 0", timed_out); end
        checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 16'h0000) begin errors++; $display("FAIL post_rst_dbg: got ack=%b data=%h expected 0/0000", dbg_ack, dbg_rdata); end
        tick();
    endtask

    task automatic test_load();
        logic [15:0] words [0:2];
        words[0] = 16'hC005; words[1] = 16'hE1FF; words[2] = 16'h0000;
        idle(); load_last = 1'b1;
        @(negedge clk);
        checks++; if (ram_wrEn !== 1'b0) begin errors++; $display("FAIL last_no_valid: got wrEn=%b expected 0", ram_wrEn); end
        tick();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = words[i]; load_last = (i == 2);
            @(negedge clk);
            checks++; if (ram_wrEn !== 1'b1 || ram_addr !== 13'(i) || ram_wdata !== words[i] || cpu_rst !== 1'b1)
                begin errors++; $display("FAIL load_beat%0d: got wrEn=%b addr=%h data=%h cpu_rst=%b expected 1/%h/%h/1", i, ram_wrEn, ram_addr, ram_wdata, cpu_rst, 13'(i), words[i]); end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL run_entry: got cpu_rst=%b load_ready=%b expected 0/0", cpu_rst, load_ready); end
        checks++; if (mem[0] !== 16'hC005 || mem[1] !== 16'hE1FF || mem[2] !== 16'h0000)
            begin errors++; $display("FAIL load_mem: got %h %h %h expected c005 e1ff 0000", mem[0], mem[1], mem[2]); end
    endtask

    task automatic test_mailbox();
        cpu_wrEn = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 16'h1234;
        @(negedge clk);
        checks++; if (ram_wrEn !== 1'b1 || ram_addr !== 13'h0005 || ram_wdata !== 16'h1234)
            begin errors++; $display("FAIL run_passthru: got wrEn=%b addr=%h data=%h expected 1/0005/1234", ram_wrEn, ram_addr, ram_wdata); end
        tick();
        cpu_wrEn = 1'b0; cpu_addr = 13'h0001;
        tick();
        cpu_wrEn = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 16'h00AB;
        @(negedge clk);
        checks++; if (ram_rdata !== 16'hE1FF) begin errors++; $display("FAIL run_read: got %h expected e1ff", ram_rdata); end
        tick();
        cpu_addr = 13'h0007; cpu_wdata = 16'h9999;
        @(negedge clk);
        checks++; if (halted !== 1'b1 || cpu_rst !== 1'b1) begin errors++; $display("FAIL mbox_halt: got halted=%b cpu_rst=%b expected 1/1", halted, cpu_rst); end
        checks++; if (halt_code !== 16'h00AB || timed_out !== 1'b0) begin errors++; $display("FAIL mbox_code: got code=%h to=%b expected 00ab/0", halt_code, timed_out); end
        checks++; if (ram_wrEn !== 1'b0) begin errors++; $display("FAIL halt_ignores_cpu: got wrEn=%b expected 0", ram_wrEn); end
        checks++; if (mem[13'h1FFF] !== 16'h00AB || mem[5] !== 16'h1234) begin errors++; $display("FAIL mbox_mem: got %h %h expected 00ab 1234", mem[13'h1FFF], mem[5]); end
        tick();
        idle();
        checks++; if (mem[7] !== 16'h0000) begin errors++; $display("FAIL halt_no_write: got %h expected 0000", mem[7]); end
    endtask

    task automatic test_debug();
        dbg_req = 1'b1; dbg_addr = 13'd2; start = 1'b1;
        @(negedge clk);
        checks++; if (ram_addr !== 13'd2 || ram_wrEn !== 1'b0) begin errors++; $display("FAIL dbg_addr: got addr=%h wrEn=%b expected 0002/0", ram_addr, ram_wrEn); end
        tick();
        dbg_req = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL dbg_wait: got ack=%b halted=%b expected 0/1", dbg_ack, halted); end
        tick();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 16'h0000) begin errors++; $display("FAIL dbg_ack2: got ack=%b data=%h expected 1/0000", dbg_ack, dbg_rdata); end
        checks++; if (halted !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL dbg_start_ignored: got halted=%b load_ready=%b expected 1/0", halted, load_ready); end
        tick();
        dbg_req = 1'b1; dbg_addr = 13'h1FFF;
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_ack_pulse: got %b expected 0", dbg_ack); end
        tick();
        dbg_req = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 16'h00AB) begin errors++; $display("FAIL dbg_read_mbox: got ack=%b data=%h expected 1/00ab", dbg_ack, dbg_rdata); end
        tick();
    endtask

    task automatic test_timeout();
        int  run_cycles = 0;
        bit  done = 1'b0;
        bit  ack_seen = 1'b0;
        idle(); start = 1'b1;
        tick();
        start = 1'b0; dbg_req = 1'b1; dbg_addr = 13'd3;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL reload: got load_ready=%b halted=%b expected 1/0", load_ready, halted); end
        if (dbg_ack) ack_seen = 1'b1;
        tick();
        load_valid = 1'b1; load_last = 1'b1; load_data = 16'hBEEF;
        @(negedge clk);
        checks++; if (ram_addr !== 13'd0 || ram_wrEn !== 1'b1) begin errors++; $display("FAIL reload_ptr: got addr=%h wrEn=%b expected 0000/1", ram_addr, ram_wrEn); end
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            dbg_req = (i < 10);
            @(negedge clk);
            if (dbg_ack) ack_seen = 1'b1;
            if (halted) done = 1'b1;
            else if (!cpu_rst) run_cycles++;
            tick();
        end
        dbg_req = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_bound: no halt within 40 cycles"); end
        checks++; if (run_cycles != 17) begin errors++; $display("FAIL timeout_cycles: got %0d expected 17", run_cycles); end
        checks++; if (timed_out !== 1'b1 || halt_code !== 16'h00AB) begin errors++; $display("FAIL timeout_flags: got to=%b code=%h expected 1/00ab", timed_out, halt_code); end
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL dbg_outside_halt: got ack seen=%b expected 0", ack_seen); end
    endtask

    task automatic test_tie();
        idle(); start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b1; load_last = 1'b1; load_data = 16'h0001;
        @(negedge clk);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL start_clears_to: got %b expected 0", timed_out); end
        tick();
        idle();
        for (int i = 0; i < 16; i++) tick();
        cpu_wrEn = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 16'h00CD;
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL tie_still_run: got cpu_rst=%b expected 0", cpu_rst); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (halted !== 1'b1 || timed_out !== 1'b0 || halt_code !== 16'h00CD)
            begin errors++; $display("FAIL tie_mbox_wins: got halted=%b to=%b code=%h expected 1/0/00cd", halted, timed_out, halt_code); end
        tick();
    endtask

    task automatic test_wrap();
        idle(); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = (i == DEPTH) ? 16'h7777 : (16'(i) ^ 16'hA5A5);
            load_last  = (i == DEPTH);
            if (i == DEPTH) begin
                @(negedge clk);
                checks++; if (ram_addr !== 13'd0) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", ram_addr); end
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (mem[0] !== 16'h7777 || mem[1] !== 16'hA5A4 || mem[DEPTH-1] !== 16'hBA5A)
            begin errors++; $display("FAIL wrap_mem: got %h %h %h expected 7777 a5a4 ba5a", mem[0], mem[1], mem[DEPTH-1]); end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL wrap_run: got cpu_rst=%b expected 0", cpu_rst); end
        tick();
    endtask

    task automatic test_reset_midrun();
        tick();
        rst = 1'b1; cpu_wrEn = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 16'hFFFF;
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1 || ram_wrEn !== 1'b0 || halted !== 1'b0 || load_ready !== 1'b0)
            begin errors++; $display("FAIL midrun_rst_out: got cpu_rst=%b wrEn=%b halted=%b ready=%b expected 1/0/0/0", cpu_rst, ram_wrEn, halted, load_ready); end
        tick();
        rst = 1'b0; idle();
        load_valid = 1'b1; load_data = 16'h4242;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1 || cpu_rst !== 1'b1 || ram_addr !== 13'd0 || ram_wrEn !== 1'b1)
            begin errors++; $display("FAIL midrun_load: got ready=%b cpu_rst=%b addr=%h wrEn=%b expected 1/1/0000/1", load_ready, cpu_rst, ram_addr, ram_wrEn); end
        checks++; if (halt_code !== 16'h0000 || timed_out !== 1'b0) begin errors++; $display("FAIL midrun_clear: got code=%h to=%b expected 0000/0", halt_code, timed_out); end
        checks++; if (mem[5] !== 16'hA5A0) begin errors++; $display("FAIL midrun_no_write: got %h expected a5a0", mem[5]); end
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b0;
        idle();
        test_reset();
        test_load();
        test_mailbox();
        test_debug();
        test_timeout();
        test_tie();
        test_wrap();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
